// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pic_pkg
// Description : Shared types and helpers for the 8259 PIC acknowledge path.
//               Holds the acknowledge FSM state type, the line count and
//               default spurious level, and the fixed-priority scan helper
//               used by both the IRR and ISR sides.
// Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    localparam int         PIC_IRQ_LINES      = 8;
    localparam logic [2:0] PIC_SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } state_t;

    // Returns {valid, index} of the lowest-index set bit. Bit 0 is the
    // highest priority under fixed priority, so this is the "most urgent" bit.
    function automatic logic [3:0] prio_lowest_set(input logic [7:0] bits);
        logic [3:0] result;
        result = 4'b0000;
        // Scan downward so the last hit is the lowest index.
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) begin
                result = {1'b1, i[2:0]};
            end
        end
        return result;
    endfunction

endpackage : pic_pkg
`default_nettype wire

// File: rtl/pic_inta_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : pic_inta_sequencer_if
// Description : Bundle between the IRR/mask logic, the OCW/ICW decoder, the
//               CPU INTA strobe and the data-bus buffer on one side, and the
//               acknowledge sequencer on the other.
//               master : drives requests, mask, INTA, config and EOI commands
//               slave  : the sequencer; returns INT, IRR clear, ISR, vector
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_inta_sequencer_if;

    logic [7:0] interrupt_request;
    logic [7:0] interrupt_mask;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       eoi_cmd;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] clear_request;
    logic [7:0] in_service_register;
    logic [7:0] data_out;
    logic       data_out_en;

    modport master (
        output interrupt_request, interrupt_mask, inta_n, vector_base,
               auto_eoi, eoi_cmd, eoi_specific, eoi_level,
        input  int_out, clear_request, in_service_register, data_out,
               data_out_en
    );

    modport slave (
        input  interrupt_request, interrupt_mask, inta_n, vector_base,
               auto_eoi, eoi_cmd, eoi_specific, eoi_level,
        output int_out, clear_request, in_service_register, data_out,
               data_out_en
    );

endinterface : pic_inta_sequencer_if
`default_nettype wire

// File: rtl/pic_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module      : pic_priority_resolver
// Description : Combinational fixed-priority resolver (IR0 highest).
//   i_irr          : latched request bits
//   i_imr          : mask bits, 1 = masked
//   i_isr          : current in-service bits
//   o_winner_valid : an unmasked request outranks every in-service level
//   o_winner_level : index of that request
//   o_isr_valid    : at least one ISR bit set
//   o_isr_level    : highest-priority (lowest-index) ISR bit, for NS-EOI
// Revision    : 1.0 - initial release
// ============================================================================
module pic_priority_resolver
    import pic_pkg::*;
(
    input  wire logic [7:0] i_irr,
    input  wire logic [7:0] i_imr,
    input  wire logic [7:0] i_isr,
    output logic            o_winner_valid,
    output logic [2:0]      o_winner_level,
    output logic            o_isr_valid,
    output logic [2:0]      o_isr_level
);

    logic [3:0] w_pend_scan;
    logic [3:0] w_isr_scan;

    // The ISR is scanned unmasked: a masked in-service level still blocks
    // everything below it.
    assign w_pend_scan = prio_lowest_set(i_irr & ~i_imr);
    assign w_isr_scan  = prio_lowest_set(i_isr);

    // Only the lowest pending index needs comparing: if it does not beat the
    // top in-service level, no higher index can either.
    assign o_winner_valid = w_pend_scan[3] &&
                            (!w_isr_scan[3] || (w_pend_scan[2:0] < w_isr_scan[2:0]));
    assign o_winner_level = w_pend_scan[2:0];
    assign o_isr_valid    = w_isr_scan[3];
    assign o_isr_level    = w_isr_scan[2:0];

endmodule : pic_priority_resolver
`default_nettype wire

// File: rtl/pic_inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pic_inta_sequencer
// Description : CPU-side acknowledge end of the 8259 PIC. Arbitrates IRR
//               against ISR, raises INT, runs the two-pulse 8086 INTA
//               handshake (set ISR, clear IRR, drive vector) and retires ISR
//               bits on EOI commands or automatic EOI.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of pic_inta_sequencer_if (requests, mask, INTA,
//             config, EOI in; INT, IRR clear, ISR, vector byte out)
// Revision    : 1.0 - initial release
// ============================================================================
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int         IRQ_LINES      = PIC_IRQ_LINES,
    parameter logic [2:0] SPURIOUS_LEVEL = PIC_SPURIOUS_LEVEL
) (
    input  wire logic            clock,
    input  wire logic            reset_n,
    pic_inta_sequencer_if.slave  bus
);

    localparam int LVL_W = $clog2(IRQ_LINES);

    state_t             r_state, w_state_nxt;
    logic               r_inta_prev;
    logic [LVL_W-1:0]   r_level, w_level_nxt;
    logic               r_spurious, w_spurious_nxt;
    logic [7:0]         r_isr, w_isr_nxt;
    logic               r_int_out, w_int_nxt;
    logic [7:0]         r_clear_req, w_clear_nxt;
    logic [7:0]         r_data_out, w_dout_nxt;
    logic               r_data_out_en, w_den_nxt;

    logic               w_fall, w_rise;
    logic               w_winner_valid, w_isr_valid;
    logic [2:0]         w_winner_level, w_isr_level;
    logic [7:0]         w_isr_set, w_aeoi_clr, w_eoi_clr;

    pic_priority_resolver u_resolver (
        .i_irr          (bus.interrupt_request),
        .i_imr          (bus.interrupt_mask),
        .i_isr          (r_isr),
        .o_winner_valid (w_winner_valid),
        .o_winner_level (w_winner_level),
        .o_isr_valid    (w_isr_valid),
        .o_isr_level    (w_isr_level)
    );

    assign w_fall =  r_inta_prev & ~bus.inta_n;
    assign w_rise = ~r_inta_prev &  bus.inta_n;

    always_comb begin
        w_state_nxt    = r_state;
        w_level_nxt    = r_level;
        w_spurious_nxt = r_spurious;
        w_int_nxt      = 1'b0;
        w_clear_nxt    = 8'h00;
        w_dout_nxt     = r_data_out;
        w_den_nxt      = r_data_out_en;
        w_isr_set      = 8'h00;
        w_aeoi_clr     = 8'h00;
        case (r_state)
            ST_IDLE: begin
                w_int_nxt = w_winner_valid;
                // A fall is acknowledged even with INT low; that is the
                // spurious path and leaves ISR/IRR untouched.
                if (w_fall) begin
                    w_int_nxt   = 1'b0;
                    w_state_nxt = ST_ACK1;
                    if (w_winner_valid) begin
                        w_level_nxt    = w_winner_level;
                        w_spurious_nxt = 1'b0;
                        w_isr_set      = 8'd1 << w_winner_level;
                        w_clear_nxt    = 8'd1 << w_winner_level;
                    end else begin
                        w_level_nxt    = SPURIOUS_LEVEL;
                        w_spurious_nxt = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                w_den_nxt = 1'b0;
                if (w_fall) begin
                    // vector_base is taken live here, not at the first pulse.
                    w_dout_nxt  = {bus.vector_base, r_level};
                    w_den_nxt   = 1'b1;
                    w_state_nxt = ST_ACK2;
                end
            end
            ST_ACK2: begin
                if (w_rise) begin
                    w_den_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (bus.auto_eoi && !r_spurious) begin
                        w_aeoi_clr = 8'd1 << r_level;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Non-specific EOI picks from the ISR before any same-cycle set.
    always_comb begin
        w_eoi_clr = 8'h00;
        if (bus.eoi_cmd) begin
            if (bus.eoi_specific) begin
                w_eoi_clr = 8'd1 << bus.eoi_level;
            end else if (w_isr_valid) begin
                w_eoi_clr = 8'd1 << w_isr_level;
            end
        end
    end

    // OR-ing the set last makes a same-cycle set win for its own index.
    assign w_isr_nxt = (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_isr_set;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_inta_prev   <= 1'b1;
            r_level       <= '0;
            r_spurious    <= 1'b0;
            r_isr         <= 8'h00;
            r_int_out     <= 1'b0;
            r_clear_req   <= 8'h00;
            r_data_out    <= 8'h00;
            r_data_out_en <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_inta_prev   <= bus.inta_n;
            r_level       <= w_level_nxt;
            r_spurious    <= w_spurious_nxt;
            r_isr         <= w_isr_nxt;
            r_int_out     <= w_int_nxt;
            r_clear_req   <= w_clear_nxt;
            r_data_out    <= w_dout_nxt;
            r_data_out_en <= w_den_nxt;
        end
    end

    assign bus.int_out             = r_int_out;
    assign bus.clear_request       = r_clear_req;
    assign bus.in_service_register = r_isr;
    assign bus.data_out            = r_data_out;
    assign bus.data_out_en         = r_data_out_en;

endmodule : pic_inta_sequencer
`default_nettype wire

// File: tb/tb_pic_inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_inta_sequencer
// Description : Directed self-checking bench for pic_inta_sequencer. Inputs
//               change 1 ns after a rising edge; registered outputs are read
//               at that same point, after the edge has taken effect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_inta_sequencer;

    logic clock;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;

    pic_inta_sequencer_if bus_if ();

    pic_inta_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full two-pulse acknowledge, ending back in IDLE.
    task automatic handshake();
        bus_if.inta_n = 1'b0; step(); step();
        bus_if.inta_n = 1'b1; step();
        bus_if.inta_n = 1'b0; step(); step();
        bus_if.inta_n = 1'b1; step();
    endtask

    initial begin
        reset_n                  = 1'b0;
        bus_if.interrupt_request = 8'h00;
        bus_if.interrupt_mask    = 8'h00;
        bus_if.inta_n            = 1'b1;
        bus_if.vector_base       = 5'h00;
        bus_if.auto_eoi          = 1'b0;
        bus_if.eoi_cmd           = 1'b0;
        bus_if.eoi_specific      = 1'b0;
        bus_if.eoi_level         = 3'd0;

        // Reset state
        #12;
        check("rst_int",  {7'd0, bus_if.int_out},     8'h00);
        check("rst_clr",  bus_if.clear_request,       8'h00);
        check("rst_isr",  bus_if.in_service_register, 8'h00);
        check("rst_dout", bus_if.data_out,            8'h00);
        check("rst_den",  {7'd0, bus_if.data_out_en}, 8'h00);
        step();
        reset_n = 1'b1;

        // IRR=28: IR3 wins, vector {08,3}=43
        bus_if.interrupt_request = 8'h28;
        bus_if.vector_base       = 5'h08;
        step(); step();
        check("t2_int_up", {7'd0, bus_if.int_out}, 8'h01);
        bus_if.inta_n = 1'b0; step();
        check("t2_clr",    bus_if.clear_request,       8'h08);
        check("t2_isr",    bus_if.in_service_register, 8'h08);
        check("t2_int_dn", {7'd0, bus_if.int_out},     8'h00);
        step();
        check("t2_clr_1cyc", bus_if.clear_request, 8'h00);
        bus_if.inta_n = 1'b1;
        bus_if.interrupt_request = 8'h20;
        step(); step();
        bus_if.inta_n = 1'b0; step();
        check("t2_dout", bus_if.data_out,            8'h43);
        check("t2_den",  {7'd0, bus_if.data_out_en}, 8'h01);
        step();
        check("t2_den_hold", {7'd0, bus_if.data_out_en}, 8'h01);
        bus_if.inta_n = 1'b1; step();
        check("t2_den_off", {7'd0, bus_if.data_out_en}, 8'h00);
        check("t2_isr_kept", bus_if.in_service_register, 8'h08);
        step();
        check("t2_ir5_blocked", {7'd0, bus_if.int_out}, 8'h00);
        bus_if.eoi_cmd = 1'b1; bus_if.eoi_specific = 1'b0; step();
        bus_if.eoi_cmd = 1'b0;
        check("t2_nseoi", bus_if.in_service_register, 8'h00);
        step();
        check("t2_ir5_int", {7'd0, bus_if.int_out}, 8'h01);
        bus_if.interrupt_request = 8'h00;
        step(); step();
        check("t2_int_idle", {7'd0, bus_if.int_out}, 8'h00);

        // Nesting: ISR=04 blocks IR4, IR1 nests above it
        bus_if.interrupt_request = 8'h04;
        step(); step();
        check("t3_int_ir2", {7'd0, bus_if.int_out}, 8'h01);
        handshake();
        check("t3_isr_04", bus_if.in_service_register, 8'h04);
        bus_if.interrupt_request = 8'h10;
        step(); step();
        check("t3_ir4_blocked", {7'd0, bus_if.int_out}, 8'h00);
        bus_if.interrupt_request = 8'h02;
        step(); step();
        check("t3_ir1_int", {7'd0, bus_if.int_out}, 8'h01);
        handshake();
        check("t3_isr_06", bus_if.in_service_register, 8'h06);
        bus_if.interrupt_request = 8'h00;

        // EOI forms
        bus_if.eoi_cmd = 1'b1; bus_if.eoi_specific = 1'b0; step();
        bus_if.eoi_cmd = 1'b0;
        check("t4_nseoi", bus_if.in_service_register, 8'h04);
        bus_if.eoi_cmd = 1'b1; bus_if.eoi_specific = 1'b1; bus_if.eoi_level = 3'd2; step();
        bus_if.eoi_cmd = 1'b0;
        check("t4_seoi2", bus_if.in_service_register, 8'h00);
        bus_if.eoi_cmd = 1'b1; bus_if.eoi_specific = 1'b1; bus_if.eoi_level = 3'd5; step();
        bus_if.eoi_cmd = 1'b0;
        check("t4_seoi_empty", bus_if.in_service_register, 8'h00);

        // Masked request raises nothing
        bus_if.interrupt_request = 8'h02;
        bus_if.interrupt_mask    = 8'h02;
        step(); step();
        check("mask_int", {7'd0, bus_if.int_out}, 8'h00);
        bus_if.interrupt_mask    = 8'h00;
        bus_if.interrupt_request = 8'h00;

        // Automatic EOI on IR0
        bus_if.auto_eoi          = 1'b1;
        bus_if.interrupt_request = 8'h01;
        step(); step();
        check("t5_int", {7'd0, bus_if.int_out}, 8'h01);
        bus_if.inta_n = 1'b0; step();
        check("t5_clr", bus_if.clear_request,       8'h01);
        check("t5_isr", bus_if.in_service_register, 8'h01);
        bus_if.interrupt_request = 8'h00;
        step();
        bus_if.inta_n = 1'b1; step();
        check("t5_isr_mid", bus_if.in_service_register, 8'h01);
        bus_if.inta_n = 1'b0; step();
        check("t5_dout", bus_if.data_out,            8'h40);
        check("t5_den",  {7'd0, bus_if.data_out_en}, 8'h01);
        bus_if.inta_n = 1'b1; step();
        check("t5_den_off", {7'd0, bus_if.data_out_en}, 8'h00);
        check("t5_aeoi",    bus_if.in_service_register, 8'h00);
        bus_if.auto_eoi = 1'b0;

        // Spurious: request vanishes before the first fall
        bus_if.interrupt_request = 8'h20;
        step(); step();
        check("t6_int", {7'd0, bus_if.int_out}, 8'h01);
        bus_if.interrupt_request = 8'h00;
        bus_if.inta_n = 1'b0; step();
        check("t6_clr",    bus_if.clear_request,       8'h00);
        check("t6_isr",    bus_if.in_service_register, 8'h00);
        check("t6_int_dn", {7'd0, bus_if.int_out},     8'h00);
        step();
        bus_if.inta_n = 1'b1; step();
        bus_if.vector_base = 5'h1F;
        bus_if.inta_n = 1'b0; step();
        check("t6_dout", bus_if.data_out,            8'hFF);
        check("t6_den",  {7'd0, bus_if.data_out_en}, 8'h01);
        bus_if.inta_n = 1'b1; step();
        check("t6_den_off", {7'd0, bus_if.data_out_en}, 8'h00);
        check("t6_isr_end", bus_if.in_service_register, 8'h00);

        // Asynchronous reset in the middle of ACK1
        bus_if.interrupt_request = 8'h04;
        step(); step();
        bus_if.inta_n = 1'b0; step();
        check("t1_isr_04", bus_if.in_service_register, 8'h04);
        step();
        bus_if.inta_n = 1'b1; step();
        #1 reset_n = 1'b0;
        #1;
        check("t1_isr", bus_if.in_service_register, 8'h00);
        check("t1_int", {7'd0, bus_if.int_out},     8'h00);
        check("t1_den", {7'd0, bus_if.data_out_en}, 8'h00);
        step();
        reset_n = 1'b1;
        step(); step();
        check("t1_idle_int", {7'd0, bus_if.int_out}, 8'h01);
        bus_if.inta_n = 1'b0; step();
        check("t1_idle_ack", bus_if.clear_request, 8'h04);
        bus_if.inta_n = 1'b1; step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pic_inta_sequencer
`default_nettype wire
